// File: rtl/impl_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : impl_mem_pkg
// Description : Shared types and constants for the OBI data-side bridge:
//               address region encoding, MMIO register selectors and the
//               default MMIO window base.
// Revision    : 1.0 - initial release
// ============================================================================
package impl_mem_pkg;

    // Region an incoming data-side address decodes to.
    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_MMIO = 2'd1,
        REG_ERR  = 2'd2
    } region_e;

    // Default base of the 16-byte MMIO window.
    localparam logic [31:0] c_mmio_base_default = 32'h1000_0000;

    // MMIO register selectors, taken from address bits [3:2] of the window
    // (byte offsets 0x0, 0x4, 0x8, 0xC).
    localparam logic [1:0] c_reg_console  = 2'd0;  // write-only
    localparam logic [1:0] c_reg_exit     = 2'd1;  // write-only
    localparam logic [1:0] c_reg_cycle_lo = 2'd2;  // read-only
    localparam logic [1:0] c_reg_cycle_hi = 2'd3;  // read-only

endpackage
`default_nettype wire

// File: rtl/impl_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module      : impl_cycle_counter
// Description : Free-running 64-bit cycle counter with a high-word shadow.
//               A low-word read latches the current high word so that a
//               following high-word read returns a value coherent with the
//               low word, even when the low word carries in between.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-high reset
//               lo_read  - pulse: low word is being read this cycle
//               count_lo - current counter low word
//               shadow   - high word captured at the last low-word read
// Revision    : 1.0 - initial release
// ============================================================================
module impl_cycle_counter #(
    parameter logic [63:0] INIT = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lo_read,
    output logic [31:0] count_lo,
    output logic [31:0] shadow
);

    logic [63:0] r_count;
    logic [31:0] r_shadow;

    // Plain binary increment: 2**64-1 rolls naturally over to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= INIT;
            r_shadow <= 32'd0;
        end else begin
            r_count <= r_count + 64'd1;
            if (lo_read) begin
                r_shadow <= r_count[63:32];
            end
        end
    end

    assign count_lo = r_count[31:0];
    assign shadow   = r_shadow;

endmodule
`default_nettype wire

// File: rtl/impl_obi_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : impl_obi_mem_bridge
// Description : OBI data-side slave connecting the core LSU to port B of the
//               dual-port RAM, plus a 16-byte MMIO window holding a console
//               byte buffer, a sticky exit register and a 64-bit cycle
//               counter. Every granted request yields exactly one response
//               one cycle later.
// Ports       : clk_i/rst_i        - clock, asynchronous active-high reset
//               data_*             - OBI request/grant/response channel
//               ram_*              - RAM port B address/strobes/data
//               tx_*               - console byte stream (valid/ready)
//               exit_valid_o/code  - sticky exit flag and first exit code
// Revision    : 1.0 - initial release
// ============================================================================
module impl_obi_mem_bridge
    import impl_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 22,
    parameter int          MEM_ADDR_WIDTH = 17,
    parameter logic [31:0] MMIO_BASE      = c_mmio_base_default,
    parameter logic [63:0] CYCLE_INIT     = 64'd0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // OBI request / response
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    input  logic [31:0]           data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,
    output logic                  data_err_o,
    // RAM port B
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i,
    // Console
    output logic                  tx_valid_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_ready_i,
    // Exit
    output logic                  exit_valid_o,
    output logic [31:0]           exit_code_o
);

    // ------------------------------------------------------------------
    // Response FSM encoding
    // ------------------------------------------------------------------
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RESP = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;

    // Decode
    region_e     w_region;
    logic [1:0]  w_reg_sel;
    logic        w_mmio;
    logic        w_sel_console;
    logic        w_sel_exit;
    logic        w_sel_lo;
    logic        w_sel_hi;
    logic        w_req_err;

    // Handshake and side-effect strobes
    logic        w_gnt;
    logic        w_console_wr;
    logic        w_exit_wr;
    logic        w_lo_rd;
    logic        w_hi_rd;

    // Registered response source
    region_e     r_src;
    logic        r_rd;
    logic        r_err;
    logic [31:0] r_mmio_rdata;

    // MMIO state
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic        r_exit_valid;
    logic [31:0] r_exit_code;

    // Cycle counter
    logic [31:0] w_count_lo;
    logic [31:0] w_shadow;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    always_comb begin
        w_region = REG_ERR;
        if ((data_addr_i >> MEM_ADDR_WIDTH) == 32'd0) begin
            w_region = REG_RAM;
        end else if (data_addr_i[31:4] == MMIO_BASE[31:4]) begin
            w_region = REG_MMIO;
        end
    end

    assign w_reg_sel     = data_addr_i[3:2];
    assign w_mmio        = (w_region == REG_MMIO);
    assign w_sel_console = w_mmio && (w_reg_sel == c_reg_console);
    assign w_sel_exit    = w_mmio && (w_reg_sel == c_reg_exit);
    assign w_sel_lo      = w_mmio && (w_reg_sel == c_reg_cycle_lo);
    assign w_sel_hi      = w_mmio && (w_reg_sel == c_reg_cycle_hi);

    // Errors: unmapped address, read of a write-only register, or write of
    // a read-only register. Errored requests are still granted and answered.
    assign w_req_err = (w_region == REG_ERR)
                    || (!data_we_i && (w_sel_console || w_sel_exit))
                    || ( data_we_i && (w_sel_lo || w_sel_hi));

    // ------------------------------------------------------------------
    // Grant: only a console write into a full buffer is back-pressured.
    // The decision uses the registered buffer state, so a byte popped this
    // cycle frees the slot for the next cycle, not this one.
    // ------------------------------------------------------------------
    assign w_gnt        = data_req_i && !(w_sel_console && data_we_i && r_tx_valid);
    assign data_gnt_o   = w_gnt;

    assign w_console_wr = w_gnt && w_sel_console && data_we_i;
    assign w_exit_wr    = w_gnt && w_sel_exit    && data_we_i;
    assign w_lo_rd      = w_gnt && w_sel_lo      && !data_we_i;
    assign w_hi_rd      = w_gnt && w_sel_hi      && !data_we_i;

    // ------------------------------------------------------------------
    // RAM port B: address and data pass straight through; the write strobe
    // is qualified so that nothing but a granted RAM write reaches the RAM.
    // ------------------------------------------------------------------
    assign ram_addr_o  = ADDR_WIDTH'(data_addr_i[MEM_ADDR_WIDTH-1:0]);
    assign ram_we_o    = w_gnt && (w_region == REG_RAM) && data_we_i;
    assign ram_be_o    = data_be_i;
    assign ram_wdata_o = data_wdata_i;

    // ------------------------------------------------------------------
    // Console single-entry buffer. A load wins over a simultaneous pop so
    // the new byte is never lost.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
        end else if (w_console_wr) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= data_wdata_i[7:0];
        end else if (r_tx_valid && tx_ready_i) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign tx_valid_o = r_tx_valid;
    assign tx_data_o  = r_tx_data;

    // ------------------------------------------------------------------
    // Exit register: the first code written sticks until reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_exit_valid <= 1'b0;
            r_exit_code  <= 32'd0;
        end else if (w_exit_wr && !r_exit_valid) begin
            r_exit_valid <= 1'b1;
            r_exit_code  <= data_wdata_i;
        end
    end

    assign exit_valid_o = r_exit_valid;
    assign exit_code_o  = r_exit_code;

    // ------------------------------------------------------------------
    // Cycle counter with coherent high-word shadow
    // ------------------------------------------------------------------
    impl_cycle_counter #(
        .INIT     (CYCLE_INIT)
    ) u_cycle_counter (
        .clk      (clk_i),
        .rst      (rst_i),
        .lo_read  (w_lo_rd),
        .count_lo (w_count_lo),
        .shadow   (w_shadow)
    );

    // ------------------------------------------------------------------
    // Response source capture. MMIO read data is registered at grant time;
    // RAM read data arrives from the RAM itself in the response cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_src        <= REG_ERR;
            r_rd         <= 1'b0;
            r_err        <= 1'b0;
            r_mmio_rdata <= 32'd0;
        end else if (w_gnt) begin
            r_src        <= w_req_err ? REG_ERR : w_region;
            r_rd         <= !data_we_i;
            r_err        <= w_req_err;
            r_mmio_rdata <= w_lo_rd ? w_count_lo :
                            w_hi_rd ? w_shadow   : 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Response FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Response FSM: next state. Any grant schedules a response next cycle,
    // from either state, which gives back-to-back throughput.
    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_next = w_gnt ? S_RESP : S_IDLE;
            S_RESP:  w_state_next = w_gnt ? S_RESP : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Response FSM: outputs. Data and error are forced to zero outside a
    // response so nothing stale is presented while idle.
    always_comb begin
        data_rvalid_o = 1'b0;
        data_rdata_o  = 32'd0;
        data_err_o    = 1'b0;
        if (r_state == S_RESP) begin
            data_rvalid_o = 1'b1;
            data_err_o    = r_err;
            case (r_src)
                REG_RAM:  data_rdata_o = r_rd ? ram_rdata_i : 32'd0;
                REG_MMIO: data_rdata_o = r_mmio_rdata;
                default:  data_rdata_o = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire
